// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: lets two requesters share a single-port synchronous memory.
// Requester 0 is the fetch unit. Requester 1 is the push/pop/load/store unit.
//
// The block runs a three-state FSM: IDLE, ACCESS and RDWAIT. Every output is
// driven from a flop.
//  - A write takes 2 cycles: the IDLE sample cycle, then ACCESS.
//  - A read takes 3 cycles: the IDLE sample, ACCESS, then RDWAIT. rvalid is
//    high in the following IDLE cycle.
//
// Optional feature (macro MEM_ARB_ROUND_ROBIN_EN):
//  - defined   : a tie goes to the requester that was not granted most
//                recently.
//  - undefined : a tie always goes to r0 (fixed priority). No pointer state
//                is built.
//
// Ports:
//  clk, rstn            clock; asynchronous active-low reset
//  rN_req/we/addr/wdata request from requester N (N = 0, 1)
//  rN_gnt               one-cycle pulse: request N accepted (high in ACCESS)
//  rN_rvalid            one-cycle pulse: rdata holds requester N's read data
//  rdata                shared read data; holds until the next read completes
//  mem_addr/data_in     memory address and write data
//  mem_r_en/w_en        memory read / write strobes (high in ACCESS)
//  mem_data_out         memory read data, valid the cycle after mem_r_en
//  dbg_state            current FSM state (IDLE=0, ACCESS=1, RDWAIT=2)
//
// Handshake: a requester raises rN_req together with we/addr/wdata. It holds
// all of them stable until it sees rN_gnt. rN_req is looked at only in IDLE,
// so a req still high in IDLE after its gnt counts as a new request.
// Nothing is queued while the FSM is busy.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_LEN = 8,
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                r0_req,
  input  logic                r0_we,
  input  logic [ADDR_LEN-1:0] r0_addr,
  input  logic [DATA_LEN-1:0] r0_wdata,
  output logic                r0_gnt,
  output logic                r0_rvalid,
  input  logic                r1_req,
  input  logic                r1_we,
  input  logic [ADDR_LEN-1:0] r1_addr,
  input  logic [DATA_LEN-1:0] r1_wdata,
  output logic                r1_gnt,
  output logic                r1_rvalid,
  output logic [DATA_LEN-1:0] rdata,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [DATA_LEN-1:0] mem_data_in,
  output logic                mem_r_en,
  output logic                mem_w_en,
  input  logic [DATA_LEN-1:0] mem_data_out,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                r0_gnt_q, r0_gnt_d;
  logic                r1_gnt_q, r1_gnt_d;
  logic                r0_rvalid_q, r0_rvalid_d;
  logic                r1_rvalid_q, r1_rvalid_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_LEN-1:0] mem_data_in_q, mem_data_in_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic                mem_w_en_q, mem_w_en_d;
  // owner_q remembers which requester started the transaction in flight, so
  // that RDWAIT can route rvalid back to it (1 = r1).
  logic                owner_q, owner_d;

  logic                pick_r1;
  logic                pick_we;
  logic [DATA_LEN-1:0] pick_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_r1_q is 1 when r1 was the most recent grant. Reset sets it to 1 so
  // that r0 wins the first tie.
  logic last_r1_q, last_r1_d;

  assign pick_r1 = r1_req & (~r0_req | ~last_r1_q);
`else
  assign pick_r1 = r1_req & ~r0_req;
`endif

  assign pick_we    = pick_r1 ? r1_we    : r0_we;
  assign pick_wdata = pick_r1 ? r1_wdata : r0_wdata;

  always_comb begin
    state_d       = state_q;
    r0_gnt_d      = 1'b0;
    r1_gnt_d      = 1'b0;
    r0_rvalid_d   = 1'b0;
    r1_rvalid_d   = 1'b0;
    mem_r_en_d    = 1'b0;
    mem_w_en_d    = 1'b0;
    rdata_d       = rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    owner_d       = owner_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_r1_d     = last_r1_q;
`endif
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          owner_d    = pick_r1;
          r0_gnt_d   = ~pick_r1;
          r1_gnt_d   = pick_r1;
          mem_addr_d = pick_r1 ? r1_addr : r0_addr;
          mem_w_en_d = pick_we;
          mem_r_en_d = ~pick_we;
          // On a read, the write-data bus keeps its previous value.
          if (pick_we) begin
            mem_data_in_d = pick_wdata;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_r1_d = pick_r1;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // mem_r_en_q is high only while a read is in ACCESS.
        state_d = mem_r_en_q ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        rdata_d     = mem_data_out;
        r0_rvalid_d = ~owner_q;
        r1_rvalid_d = owner_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      r0_gnt_q      <= 1'b0;
      r1_gnt_q      <= 1'b0;
      r0_rvalid_q   <= 1'b0;
      r1_rvalid_q   <= 1'b0;
      rdata_q       <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_r_en_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
      owner_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_r1_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      r0_gnt_q      <= r0_gnt_d;
      r1_gnt_q      <= r1_gnt_d;
      r0_rvalid_q   <= r0_rvalid_d;
      r1_rvalid_q   <= r1_rvalid_d;
      rdata_q       <= rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_r_en_q    <= mem_r_en_d;
      mem_w_en_q    <= mem_w_en_d;
      owner_q       <= owner_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_r1_q     <= last_r1_d;
`endif
    end
  end

  assign r0_gnt      = r0_gnt_q;
  assign r1_gnt      = r1_gnt_q;
  assign r0_rvalid   = r0_rvalid_q;
  assign r1_rvalid   = r1_rvalid_q;
  assign rdata       = rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_r_en    = mem_r_en_q;
  assign mem_w_en    = mem_w_en_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter.
//  - A behavioural memory answers the DUT's strobes.
//  - Directed tasks cover reset, a single write, a single read, ties,
//    reset during RDWAIT, and a request arriving while the FSM is busy.
//  - A random phase is checked against a transaction-level model. The model
//    uses a "next free cycle" counter, a shadow memory and an expected
//    read-data queue.
// Build with +define+MEM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int NCYC = 400;

  logic       clk;
  logic       rstn;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] rdata, mem_addr, mem_data_in, mem_data_out;
  logic       mem_r_en, mem_w_en;
  logic [1:0] dbg_state;
  logic [29:0] all_out;

  int checks   = 0;
  int failures = 0;

  // Expected read data, in completion order.
  logic [7:0] exp_q[$];
  logic [7:0] shadow [256];
  logic [7:0] mem_arr [256];
  logic       last_r1;

  // Per-cycle expectations for the random phase.
  logic e_g0 [NCYC+8];
  logic e_g1 [NCYC+8];
  logic e_v0 [NCYC+8];
  logic e_v1 [NCYC+8];
  logic e_re [NCYC+8];
  logic e_we [NCYC+8];
  logic [7:0] e_ad [NCYC+8];
  logic [7:0] e_wd [NCYC+8];

  mem_port_arbiter #(.ADDR_LEN(8), .DATA_LEN(8)) dut (
    .clk(clk), .rstn(rstn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_data_out(mem_data_out),
    .dbg_state(dbg_state)
  );

  assign all_out = {r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_r_en, mem_w_en,
                    rdata, mem_addr, mem_data_in};

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural synchronous memory: read data appears one cycle after mem_r_en.
  always @(posedge clk) begin
    if (mem_w_en) mem_arr[mem_addr] = mem_data_in;
    if (mem_r_en) mem_data_out <= mem_arr[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required $finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  // Advance one cycle. Sampling happens 1 time unit after the edge. The
  // mutual-exclusion rules are checked on every cycle.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    if (mem_r_en === 1'b1 && mem_w_en === 1'b1) begin
      failures++;
      $display("FAIL strobe_excl: got r_en=%b w_en=%b, required not both", mem_r_en, mem_w_en);
    end
    checks++;
    if ((r0_gnt === 1'b1 && r1_gnt === 1'b1) || (r0_rvalid === 1'b1 && r1_rvalid === 1'b1)) begin
      failures++;
      $display("FAIL pulse_excl: got gnt=%b%b rvalid=%b%b, required at most one each",
               r0_gnt, r1_gnt, r0_rvalid, r1_rvalid);
    end
  endtask

  task automatic clear_inputs();
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  // Returns 1 time unit after an edge with rstn high; the next edge samples.
  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    last_r1 = 1'b1;
    exp_q.delete();
  endtask

  // Tests
  task automatic test_reset();
    clear_inputs();
    rstn = 1'b1;
    #2;
    rstn = 1'b0;
    #1;  // no clock edge between these two points
    checks++;
    if (all_out !== 30'd0) begin
      failures++;
      $display("FAIL reset_async_outputs: got %h, required 0", all_out);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    apply_reset();
    checks++;
    if (all_out !== 30'd0) begin
      failures++;
      $display("FAIL reset_release_outputs: got %h, required 0", all_out);
    end
  endtask

  task automatic test_write();
    apply_reset();
    r1_req = 1; r1_we = 1; r1_addr = 8'h10; r1_wdata = 8'hA5;
    step();
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b01) begin
      failures++;
      $display("FAIL wr_gnt: got r0/r1=%b%b, required 01", r0_gnt, r1_gnt);
    end
    checks++;
    if ({mem_w_en, mem_r_en, mem_addr, mem_data_in} !== {2'b10, 8'h10, 8'hA5}) begin
      failures++;
      $display("FAIL wr_access: got w=%b r=%b a=%h d=%h, required w=1 r=0 a=10 d=a5",
               mem_w_en, mem_r_en, mem_addr, mem_data_in);
    end
    r1_req = 0;
    shadow[8'h10] = 8'hA5;
    last_r1 = 1'b1;
    step();
    checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_w_en, mem_r_en} !== 6'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL wr_done: got flags=%b state=%0d, required 0 / IDLE",
               {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_w_en, mem_r_en}, dbg_state);
    end
  endtask

  task automatic test_read();
    r0_req = 1; r0_we = 0; r0_addr = 8'h10;
    step();
    checks++;
    if ({r0_gnt, r1_gnt, mem_r_en, mem_w_en} !== 4'b1010 || mem_addr !== 8'h10) begin
      failures++;
      $display("FAIL rd_access: got gnt=%b%b r=%b w=%b a=%h, required 10 1 0 10",
               r0_gnt, r1_gnt, mem_r_en, mem_w_en, mem_addr);
    end
    r0_req = 0;
    last_r1 = 1'b0;
    step();
    checks++;
    if ({r0_gnt, mem_r_en, r0_rvalid} !== 3'b000 || dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL rd_wait: got gnt=%b r=%b rv=%b st=%0d, required 0 0 0 2",
               r0_gnt, mem_r_en, r0_rvalid, dbg_state);
    end
    step();
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b10 || rdata !== shadow[8'h10]) begin
      failures++;
      $display("FAIL rd_rvalid: got rv=%b%b rdata=%h, required 10 %h",
               r0_rvalid, r1_rvalid, rdata, shadow[8'h10]);
    end
    step();
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b00 || rdata !== 8'hA5) begin
      failures++;
      $display("FAIL rd_hold: got rv=%b%b rdata=%h, required 00 a5", r0_rvalid, r1_rvalid, rdata);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_w[$];
    logic [1:0] w;
    apply_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_w = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp_w = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    r0_req = 1; r0_we = 1; r0_addr = 8'h20; r0_wdata = 8'h3C;
    r1_req = 1; r1_we = 1; r1_addr = 8'h21; r1_wdata = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      step();
      w = exp_w.pop_front();
      checks++;
      if ({r0_gnt, r1_gnt} !== w) begin
        failures++;
        $display("FAIL tie_grant%0d: got r0/r1=%b%b, required %b", k, r0_gnt, r1_gnt, w);
      end
      if (w[0]) shadow[8'h21] = 8'hC3;
      else      shadow[8'h20] = 8'h3C;
      last_r1 = w[0];
      step();
    end
    clear_inputs();
    step();
  endtask

  task automatic test_reset_rdwait();
    apply_reset();
    r1_req = 1; r1_we = 0; r1_addr = 8'h30;
    step();
    checks++;
    if (r1_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rst_rd_gnt: got %b, required 1", r1_gnt);
    end
    r1_req = 0;
    step();
    checks++;
    if (dbg_state !== 2'd2) begin
      failures++;
      $display("FAIL rst_rd_state: got %0d, required 2", dbg_state);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (all_out !== 30'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL rst_rd_async: got out=%h st=%0d, required 0 0", all_out, dbg_state);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    last_r1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (all_out !== 30'd0) begin
        failures++;
        $display("FAIL rst_rd_abandon%0d: got %h, required 0", k, all_out);
      end
    end
    r0_req = 1; r0_we = 0; r0_addr = 8'h10;
    r1_req = 1; r1_we = 0; r1_addr = 8'h30;
    step();
    checks++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      failures++;
      $display("FAIL rst_rd_tie: got r0/r1=%b%b, required 10", r0_gnt, r1_gnt);
    end
    clear_inputs();
    last_r1 = 1'b0;
    step();
    step();
    checks++;
    if ({r0_rvalid, r1_rvalid} !== 2'b10 || rdata !== shadow[8'h10]) begin
      failures++;
      $display("FAIL rst_rd_after: got rv=%b%b rdata=%h, required 10 %h",
               r0_rvalid, r1_rvalid, rdata, shadow[8'h10]);
    end
    step();
  endtask

  task automatic test_busy_ignore();
    apply_reset();
    r0_req = 1; r0_we = 0; r0_addr = 8'h10;
    step();
    r0_req = 0;
    r1_req = 1; r1_we = 1; r1_addr = 8'h40; r1_wdata = 8'h5A;
    step();
    checks++;
    if (r1_gnt !== 1'b0 || mem_w_en !== 1'b0) begin
      failures++;
      $display("FAIL busy_rdwait: got r1_gnt=%b w=%b, required 0 0", r1_gnt, mem_w_en);
    end
    step();
    checks++;
    if (r1_gnt !== 1'b0 || r0_rvalid !== 1'b1 || rdata !== shadow[8'h10]) begin
      failures++;
      $display("FAIL busy_idle: got r1_gnt=%b rv0=%b rdata=%h, required 0 1 %h",
               r1_gnt, r0_rvalid, rdata, shadow[8'h10]);
    end
    step();
    checks++;
    if (r1_gnt !== 1'b1 || mem_w_en !== 1'b1 || mem_addr !== 8'h40 || mem_data_in !== 8'h5A) begin
      failures++;
      $display("FAIL busy_late_gnt: got g=%b w=%b a=%h d=%h, required 1 1 40 5a",
               r1_gnt, mem_w_en, mem_addr, mem_data_in);
    end
    r1_req = 0;
    shadow[8'h40] = 8'h5A;
    step();
    checks++;
    if (r1_gnt !== 1'b0 || mem_w_en !== 1'b0) begin
      failures++;
      $display("FAIL busy_end: got g=%b w=%b, required 0 0", r1_gnt, mem_w_en);
    end
  endtask

  // Transaction-level model. A request seen in cycle c while the port is free
  // wins according to the tie rule. Its gnt and strobe appear in cycle c+1.
  // A write frees the port at c+2. A read returns rvalid at c+3 and frees
  // the port at c+3.
  task automatic test_random();
    logic       p0, p1, w;
    logic       pw [2];
    logic [7:0] pa [2];
    logic [7:0] pd [2];
    int         free_at;
    logic [7:0] ed;
    apply_reset();
    for (int i = 0; i < NCYC + 8; i++) begin
      e_g0[i] = 0; e_g1[i] = 0; e_v0[i] = 0; e_v1[i] = 0;
      e_re[i] = 0; e_we[i] = 0; e_ad[i] = 0; e_wd[i] = 0;
    end
    p0 = 0; p1 = 0; free_at = 0;
    for (int c = 0; c < NCYC + 4; c++) begin
      if (c > 0) begin
        checks++;
        if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== {e_g0[c], e_g1[c], e_v0[c], e_v1[c]}) begin
          failures++;
          $display("FAIL rnd_pulses c=%0d: got g=%b%b v=%b%b, required g=%b%b v=%b%b", c,
                   r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, e_g0[c], e_g1[c], e_v0[c], e_v1[c]);
        end
        checks++;
        if ({mem_r_en, mem_w_en} !== {e_re[c], e_we[c]}) begin
          failures++;
          $display("FAIL rnd_strobe c=%0d: got r=%b w=%b, required r=%b w=%b", c,
                   mem_r_en, mem_w_en, e_re[c], e_we[c]);
        end
        if (e_re[c] || e_we[c]) begin
          checks++;
          if (mem_addr !== e_ad[c] || (e_we[c] && mem_data_in !== e_wd[c])) begin
            failures++;
            $display("FAIL rnd_bus c=%0d: got a=%h d=%h, required a=%h d=%h", c,
                     mem_addr, mem_data_in, e_ad[c], e_wd[c]);
          end
        end
        if (r0_rvalid === 1'b1 || r1_rvalid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rnd_rdata c=%0d: got unexpected rvalid rdata=%h, required none", c, rdata);
          end else begin
            ed = exp_q.pop_front();
            if (rdata !== ed) begin
              failures++;
              $display("FAIL rnd_rdata c=%0d: got %h, required %h", c, rdata, ed);
            end
          end
        end
      end
      // Requesters drop req once they have their grant.
      if (e_g0[c]) begin p0 = 0; r0_req = 0; end
      if (e_g1[c]) begin p1 = 0; r1_req = 0; end
      if (c < NCYC - 8) begin
        if (!p0 && $urandom_range(0, 3) == 0) begin
          p0 = 1; pw[0] = 1'($urandom_range(0, 1));
          pa[0] = 8'($urandom_range(0, 7)); pd[0] = 8'($urandom_range(0, 255));
          r0_req = 1; r0_we = pw[0]; r0_addr = pa[0]; r0_wdata = pd[0];
        end
        if (!p1 && $urandom_range(0, 3) == 0) begin
          p1 = 1; pw[1] = 1'($urandom_range(0, 1));
          pa[1] = 8'($urandom_range(0, 7)); pd[1] = 8'($urandom_range(0, 255));
          r1_req = 1; r1_we = pw[1]; r1_addr = pa[1]; r1_wdata = pd[1];
        end
      end
      if (c >= free_at && (p0 || p1)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        w = p1 && (!p0 || !last_r1);
`else
        w = p1 && !p0;
`endif
        if (w) e_g1[c+1] = 1; else e_g0[c+1] = 1;
        e_ad[c+1] = pa[w];
        if (pw[w]) begin
          e_we[c+1] = 1;
          e_wd[c+1] = pd[w];
          shadow[pa[w]] = pd[w];
          free_at = c + 2;
        end else begin
          e_re[c+1] = 1;
          if (w) e_v1[c+3] = 1; else e_v0[c+3] = 1;
          exp_q.push_back(shadow[pa[w]]);
          free_at = c + 3;
        end
        last_r1 = w;
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rnd_drain: got %0d reads outstanding, required 0", exp_q.size());
    end
  endtask

  // Final report
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'(i * 7 + 3);
      shadow[i]  = 8'(i * 7 + 3);
    end
    test_reset();
    test_write();
    test_read();
    test_tie();
    test_reset_rdwait();
    test_busy_ignore();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
